// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: one-entry stereo holding buffer with valid/ready,
// bclk/lrck generation from the system clock, MSB-first serial data with the
// MSB one bclk after each lrck edge.
module i2s_tx_serializer #(
  parameter int CLK_DIV      = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] leftSampleIn,
  input  logic [SAMPLE_WIDTH-1:0] rightSampleIn,
  input  logic                    sampleValid,
  output logic                    sampleReady,
  output logic                    frameStrobe,
  output logic                    underrun,
  output logic                    bclk,
  output logic                    lrck,
  output logic                    sdata
);

  localparam int CNT_W  = $clog2(2 * SLOT_WIDTH);
  localparam int SLOT_W = $clog2(SLOT_WIDTH);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0]        div_cnt_reg;
  logic                    bclk_reg;
  logic                    lrck_reg;
  logic                    sdata_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic                    hold_full_reg;
  logic [SAMPLE_WIDTH-1:0] hold_left_reg;
  logic [SAMPLE_WIDTH-1:0] hold_right_reg;
  logic [SAMPLE_WIDTH-1:0] frame_left_reg;
  logic [SAMPLE_WIDTH-1:0] frame_right_reg;
  logic                    ready_reg;
  logic                    strobe_reg;
  logic                    underrun_reg;

  logic                    div_wrap;
  logic                    fall_event;
  logic                    frame_load;
  logic                    accept;
  logic [CNT_W-1:0]        bit_cnt_next;
  logic                    lrck_next;
  logic [SLOT_W-1:0]       slot_idx;
  logic                    sdata_next;
  logic                    hold_full_next;
  logic [SLOT_WIDTH-1:0]   left_slot;
  logic [SLOT_WIDTH-1:0]   right_slot;

  // Slot images: sample bits sit at slot positions 1..SAMPLE_WIDTH, MSB first;
  // position 0 (the bclk right after the lrck edge) and the tail are zero pad.
  genvar gi;
  generate
    for (gi = 0; gi < SLOT_WIDTH; gi++) begin : g_slot
      if (gi >= 1 && gi <= SAMPLE_WIDTH) begin : g_data
        assign left_slot[gi]  = frame_left_reg[SAMPLE_WIDTH-gi];
        assign right_slot[gi] = frame_right_reg[SAMPLE_WIDTH-gi];
      end else begin : g_pad
        assign left_slot[gi]  = 1'b0;
        assign right_slot[gi] = 1'b0;
      end
    end
  endgenerate

  // Falling-edge detection, next bit position and the serial bit it carries.
  always_comb begin
    div_wrap     = (div_cnt_reg == DIV_LAST);
    fall_event   = div_wrap && bclk_reg;
    bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
    frame_load   = fall_event && (bit_cnt_next == '0);
    accept       = sampleValid && ready_reg;
    lrck_next    = (bit_cnt_next >= SLOT_LEN);
    slot_idx     = SLOT_W'(lrck_next ? (bit_cnt_next - SLOT_LEN) : bit_cnt_next);
    sdata_next   = lrck_next ? right_slot[slot_idx] : left_slot[slot_idx];
  end

  // Buffer occupancy: a load empties it; an accept (only possible while empty)
  // fills it and wins over a same-cycle load, which then went out silent.
  always_comb begin
    hold_full_next = hold_full_reg;
    if (frame_load) hold_full_next = 1'b0;
    if (accept)     hold_full_next = 1'b1;
  end

  // Bit clock divider and serial shift timing; outputs change only on bclk fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
      lrck_reg    <= 1'b1;
      sdata_reg   <= 1'b0;
      bit_cnt_reg <= BIT_LAST;
    end else begin
      div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + 1'b1;
      if (div_wrap) bclk_reg <= ~bclk_reg;
      if (fall_event) begin
        bit_cnt_reg <= bit_cnt_next;
        lrck_reg    <= lrck_next;
        sdata_reg   <= sdata_next;
      end
    end
  end

  // Holding buffer handshake and frame loading with underrun signalling.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_reg   <= 1'b0;
      hold_left_reg   <= '0;
      hold_right_reg  <= '0;
      frame_left_reg  <= '0;
      frame_right_reg <= '0;
      ready_reg       <= 1'b0;
      strobe_reg      <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      if (accept) begin
        hold_left_reg  <= leftSampleIn;
        hold_right_reg <= rightSampleIn;
      end
      if (frame_load) begin
        frame_left_reg  <= hold_full_reg ? hold_left_reg  : '0;
        frame_right_reg <= hold_full_reg ? hold_right_reg : '0;
      end
      hold_full_reg <= hold_full_next;
      ready_reg     <= ~hold_full_next;
      strobe_reg    <= frame_load;
      underrun_reg  <= frame_load && !hold_full_reg;
    end
  end

  assign sampleReady = ready_reg;
  assign frameStrobe = strobe_reg;
  assign underrun    = underrun_reg;
  assign bclk        = bclk_reg;
  assign lrck        = lrck_reg;
  assign sdata       = sdata_reg;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer (CLK_DIV=2, 16-bit samples, 32-bit slots).
module tb_i2s_tx_serializer;

  localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;
  localparam logic [63:0] LRCK_PAT  = 64'hFFFF_FFFF_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_in = '0;
  logic [15:0] right_in = '0;
  logic        valid = 1'b0;
  logic        ready, strobe, under, bclk, lrck, sdata;

  int checks = 0;
  int errors = 0;

  i2s_tx_serializer #(.CLK_DIV(2), .SAMPLE_WIDTH(16), .SLOT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .leftSampleIn(left_in), .rightSampleIn(right_in), .sampleValid(valid),
    .sampleReady(ready), .frameStrobe(strobe), .underrun(under),
    .bclk(bclk), .lrck(lrck), .sdata(sdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until frameStrobe is seen; returns the number of clocks waited.
  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (strobe !== 1'b1 && cycles < 600);
    checks++;
    if (strobe !== 1'b1) begin
      errors++;
      $display("FAIL strobe_timeout: frameStrobe=%b after %0d clk, required 1", strobe, cycles);
    end
  endtask

  // Collect the 64 (lrck, sdata) pairs the DAC latches on bclk rises of one frame.
  task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr);
    int   n = 0;
    int   guard = 0;
    logic prev;
    sd = '0;
    lr = '0;
    prev = bclk;
    while (n < 64 && guard < 1000) begin
      tick();
      guard++;
      if (bclk && !prev) begin
        sd[n] = sdata;
        lr[n] = lrck;
        n++;
      end
      prev = bclk;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL capture_timeout: got %0d bclk rises, required 64", n);
    end
  endtask

  function automatic logic [15:0] slot_word(input logic [63:0] sd, input int base);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[15-k] = sd[base+1+k];
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if ({bclk, lrck, sdata, ready, strobe, under} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_state: bclk,lrck,sdata,ready,strobe,under=%b required 010000",
               {bclk, lrck, sdata, ready, strobe, under});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1 || bclk !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%b bclk=%b required ready=1 bclk=0", ready, bclk);
    end
    $display("test_reset done");
  endtask

  task automatic test_first_frame();
    int          cyc;
    logic [63:0] sd, lr;
    left_in = 16'hA5C3; right_in = 16'h0F0F; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_ready: ready=%b required 0", ready);
    end
    wait_strobe(cyc);
    checks++;
    if (cyc != 2 || under !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL first_load: clk=%0d under=%b ready=%b required 2,0,1", cyc, under, ready);
    end
    capture_frame(sd, lr);
    checks++;
    if (slot_word(sd, 0) !== 16'hA5C3 || slot_word(sd, 32) !== 16'h0F0F) begin
      errors++;
      $display("FAIL first_data: L=%h R=%h required L=a5c3 R=0f0f", slot_word(sd, 0), slot_word(sd, 32));
    end
    checks++;
    if ((sd & ~DATA_MASK) !== 64'h0 || lr !== LRCK_PAT) begin
      errors++;
      $display("FAIL first_framing: pad=%h lrck=%h required pad=0 lrck=%h", sd & ~DATA_MASK, lr, LRCK_PAT);
    end
    $display("test_first_frame: L=%h R=%h", slot_word(sd, 0), slot_word(sd, 32));
  endtask

  task automatic test_underrun();
    int cyc, nz, extra;
    wait_strobe(cyc);
    checks++;
    if (under !== 1'b1) begin
      errors++;
      $display("FAIL underrun_first: under=%b required 1", under);
    end
    for (int f = 0; f < 3; f++) begin
      cyc = 0; nz = 0; extra = 0;
      do begin
        tick();
        cyc++;
        if (sdata !== 1'b0) nz++;
        if (strobe !== 1'b1 && under !== 1'b0) extra++;
      end while (strobe !== 1'b1 && cyc < 600);
      checks++;
      if (cyc != 256 || under !== 1'b1 || nz != 0 || extra != 0) begin
        errors++;
        $display("FAIL underrun_frame%0d: period=%0d under=%b sdata_ones=%0d stray=%0d required 256,1,0,0",
                 f, cyc, under, nz, extra);
      end
      $display("test_underrun frame %0d: period=%0d", f, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int          cyc, bad;
    logic [63:0] sd, lr;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_start: ready=%b required 1", ready);
    end
    left_in = 16'h1234; right_in = 16'h5678; valid = 1'b1;
    tick();
    left_in = 16'h9ABC; right_in = 16'hDEF0;
    cyc = 0; bad = 0;
    if (ready !== 1'b0) bad++;
    while (strobe !== 1'b1 && cyc < 600) begin
      tick();
      cyc++;
      if (strobe !== 1'b1 && ready !== 1'b0) bad++;
    end
    checks++;
    if (cyc != 255 || bad != 0 || ready !== 1'b1 || under !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: wait=%0d ready_high=%0d ready=%b under=%b required 255,0,1,0",
               cyc, bad, ready, under);
    end
    fork
      capture_frame(sd, lr);
      begin
        tick();
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_p2_accept: ready=%b required 0", ready);
        end
        valid = 1'b0;
      end
    join
    checks++;
    if (slot_word(sd, 0) !== 16'h1234 || slot_word(sd, 32) !== 16'h5678) begin
      errors++;
      $display("FAIL b2b_p1: L=%h R=%h required L=1234 R=5678", slot_word(sd, 0), slot_word(sd, 32));
    end
    $display("test_back_to_back P1: L=%h R=%h", slot_word(sd, 0), slot_word(sd, 32));
    wait_strobe(cyc);
    checks++;
    if (under !== 1'b0) begin
      errors++;
      $display("FAIL b2b_p2_load: under=%b required 0", under);
    end
    capture_frame(sd, lr);
    checks++;
    if (slot_word(sd, 0) !== 16'h9ABC || slot_word(sd, 32) !== 16'hDEF0) begin
      errors++;
      $display("FAIL b2b_p2: L=%h R=%h required L=9abc R=def0", slot_word(sd, 0), slot_word(sd, 32));
    end
    $display("test_back_to_back P2: L=%h R=%h", slot_word(sd, 0), slot_word(sd, 32));
  endtask

  task automatic test_extremes();
    int          cyc;
    logic [63:0] sd, lr;
    left_in = 16'h8000; right_in = 16'h7FFF; valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_strobe(cyc);
    checks++;
    if (cyc != 1 || under !== 1'b0) begin
      errors++;
      $display("FAIL ext_load: clk=%0d under=%b required 1,0", cyc, under);
    end
    capture_frame(sd, lr);
    checks++;
    if (slot_word(sd, 0) !== 16'h8000 || slot_word(sd, 32) !== 16'h7FFF ||
        (sd & ~DATA_MASK) !== 64'h0) begin
      errors++;
      $display("FAIL ext_data: L=%h R=%h pad=%h required L=8000 R=7fff pad=0",
               slot_word(sd, 0), slot_word(sd, 32), sd & ~DATA_MASK);
    end
    $display("test_extremes: L=%h R=%h", slot_word(sd, 0), slot_word(sd, 32));
  endtask

  task automatic test_reset_midframe();
    int          cyc, rises, guard;
    logic        prev;
    logic [63:0] sd, lr;
    wait_strobe(cyc);
    checks++;
    if (under !== 1'b1) begin
      errors++;
      $display("FAIL mid_silent_load: under=%b required 1", under);
    end
    left_in = 16'h1111; right_in = 16'h2222; valid = 1'b1;
    tick();
    valid = 1'b0;
    rises = 0; guard = 0; prev = bclk;
    while (rises < 21 && guard < 400) begin
      tick();
      guard++;
      if (bclk && !prev) rises++;
      prev = bclk;
    end
    checks++;
    if (ready !== 1'b0 || lrck !== 1'b0 || rises != 21) begin
      errors++;
      $display("FAIL mid_before_reset: ready=%b lrck=%b rises=%0d required 0,0,21", ready, lrck, rises);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bclk, lrck, sdata, ready, strobe, under} !== 6'b010000) begin
      errors++;
      $display("FAIL mid_reset_state: bclk,lrck,sdata,ready,strobe,under=%b required 010000",
               {bclk, lrck, sdata, ready, strobe, under});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: ready=%b required 1", ready);
    end
    wait_strobe(cyc);
    checks++;
    if (cyc != 3 || under !== 1'b1) begin
      errors++;
      $display("FAIL mid_first_load: clk=%0d under=%b required 3,1", cyc, under);
    end
    capture_frame(sd, lr);
    checks++;
    if (sd !== 64'h0 || lr !== LRCK_PAT) begin
      errors++;
      $display("FAIL mid_silent_frame: sdata=%h lrck=%h required 0 and %h", sd, lr, LRCK_PAT);
    end
    $display("test_reset_midframe: sdata=%h", sd);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_back_to_back();
    test_extremes();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
